// File: rtl/cobs_pkg.sv
// rtl/cobs_pkg.sv - shared constants and FSM state type for the COBS decoder
package cobs_pkg;

  localparam logic [7:0] COBS_DELIMITER = 8'h00;
  localparam logic [7:0] COBS_MAX_CODE  = 8'hFF;

  typedef enum logic [1:0] {
    ST_CODE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_ZERO  = 2'd2,
    ST_FLUSH = 2'd3
  } cobs_state_t;

endpackage

// File: rtl/cobs_byte_packer.sv
// rtl/cobs_byte_packer.sv - packs decoded bytes little-endian into output words
// A full word is held in the accumulator until the next byte or the frame flush decides its tlast.
module cobs_byte_packer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    flush,
  input  logic                    flush_error,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   word_tdata,
  output logic [DATA_WIDTH/8-1:0] word_tkeep,
  output logic                    word_tlast,
  output logic                    word_tuser,
  output logic                    word_tvalid,
  input  logic                    word_tready
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(LANES + 1);

  logic [DATA_WIDTH-1:0] acc_q;
  logic [CW-1:0]         fill_q;
  logic [LANES-1:0]      fill_keep;
  logic                  acc_full;

  assign ready    = !word_tvalid || word_tready;
  assign acc_full = (fill_q == CW'(LANES));

  always_comb begin
    fill_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      fill_keep[i] = (CW'(i) < fill_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      fill_q      <= '0;
      word_tdata  <= '0;
      word_tkeep  <= '0;
      word_tlast  <= 1'b0;
      word_tuser  <= 1'b0;
      word_tvalid <= 1'b0;
    end else begin
      if (word_tvalid && word_tready) begin
        word_tvalid <= 1'b0;
      end
      if (ready && push) begin
        if (acc_full) begin
          // The held word is now known not to be the last one of the frame.
          word_tdata  <= acc_q;
          word_tkeep  <= '1;
          word_tlast  <= 1'b0;
          word_tuser  <= 1'b0;
          word_tvalid <= 1'b1;
          acc_q       <= DATA_WIDTH'(push_data);
          fill_q      <= CW'(1);
        end else begin
          acc_q[8*int'(fill_q) +: 8] <= push_data;
          fill_q                     <= fill_q + CW'(1);
        end
      end else if (ready && flush && (fill_q != '0)) begin
        word_tdata  <= acc_q;
        word_tkeep  <= fill_keep;
        word_tlast  <= 1'b1;
        word_tuser  <= flush_error;
        word_tvalid <= 1'b1;
        acc_q       <= '0;
        fill_q      <= '0;
      end
    end
  end

endmodule

// File: rtl/cobs_axis_decoder.sv
// rtl/cobs_axis_decoder.sv - COBS byte stream to framed word stream decoder
// Optional malformed-frame flag on tuser[0] is enabled by defining COBS_DECODER_ERROR_EN.
module cobs_axis_decoder
  import cobs_pkg::*;
#(
  parameter int S_DATA_WIDTH = 8,
  parameter int M_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [S_DATA_WIDTH-1:0]   encoded_data_tdata,
  input  logic                      encoded_data_tvalid,
  output logic                      encoded_data_tready,
  output logic [M_DATA_WIDTH-1:0]   decoded_data_tdata,
  output logic [M_DATA_WIDTH/8-1:0] decoded_data_tkeep,
  output logic                      decoded_data_tlast,
  output logic [0:0]                decoded_data_tuser,
  output logic                      decoded_data_tvalid,
  input  logic                      decoded_data_tready
);

  cobs_state_t state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  count_q, count_d;
  logic        zp_q, zp_d;

  logic [7:0]  in_byte;
  logic        in_ready;
  logic        pk_ready;
  logic        pk_push;
  logic [7:0]  pk_byte;
  logic        pk_flush;
  logic        pk_flush_err;

  assign in_byte = encoded_data_tdata[7:0];

  // Input is held off during reset so no byte is taken before the FSM is live.
  assign encoded_data_tready = rst_n && in_ready;

`ifdef COBS_DECODER_ERROR_EN
  assign pk_flush_err = (state_q == ST_DATA);
`else
  assign pk_flush_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CODE;
      code_q  <= '0;
      count_q <= '0;
      zp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      count_q <= count_d;
      zp_q    <= zp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    count_d  = count_q;
    zp_d     = zp_q;
    in_ready = 1'b0;
    pk_push  = 1'b0;
    pk_byte  = '0;
    pk_flush = 1'b0;
    case (state_q)
      ST_CODE: begin
        in_ready = pk_ready;
        if (encoded_data_tvalid && pk_ready) begin
          if (in_byte == COBS_DELIMITER) begin
            pk_flush = 1'b1;
            zp_d     = 1'b0;
            state_d  = ST_FLUSH;
          end else begin
            code_d  = in_byte;
            count_d = in_byte - 8'd1;
            if (zp_q) begin
              state_d = ST_ZERO;
            end else if (in_byte == 8'd1) begin
              zp_d    = 1'b1;
              state_d = ST_CODE;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_ZERO: begin
        // The previous block's implicit zero is only known once a nonzero code follows.
        if (pk_ready) begin
          pk_push = 1'b1;
          pk_byte = 8'h00;
          if (code_q == 8'd1) begin
            zp_d    = 1'b1;
            state_d = ST_CODE;
          end else begin
            zp_d    = 1'b0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        in_ready = pk_ready;
        if (encoded_data_tvalid && pk_ready) begin
          if (in_byte == COBS_DELIMITER) begin
            pk_flush = 1'b1;
            zp_d     = 1'b0;
            state_d  = ST_FLUSH;
          end else begin
            pk_push = 1'b1;
            pk_byte = in_byte;
            count_d = count_q - 8'd1;
            if (count_q == 8'd1) begin
              zp_d    = (code_q != COBS_MAX_CODE);
              state_d = ST_CODE;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_CODE;
      end
      default: begin
        state_d = ST_CODE;
      end
    endcase
  end

  cobs_byte_packer #(
    .DATA_WIDTH (M_DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (pk_push),
    .push_data   (pk_byte),
    .flush       (pk_flush),
    .flush_error (pk_flush_err),
    .ready       (pk_ready),
    .word_tdata  (decoded_data_tdata),
    .word_tkeep  (decoded_data_tkeep),
    .word_tlast  (decoded_data_tlast),
    .word_tuser  (decoded_data_tuser[0]),
    .word_tvalid (decoded_data_tvalid),
    .word_tready (decoded_data_tready)
  );

endmodule

// File: tb/tb_cobs_axis_decoder.sv
// tb/tb_cobs_axis_decoder.sv - directed self-checking bench for cobs_axis_decoder
module tb_cobs_axis_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  enc_tdata = '0;
  logic        enc_tvalid = 1'b0;
  logic        enc_tready;
  logic [15:0] dec_tdata;
  logic [1:0]  dec_tkeep;
  logic        dec_tlast;
  logic [0:0]  dec_tuser;
  logic        dec_tvalid;
  logic        dec_tready = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [19:0] cap[$];
  logic [7:0]  tx[$];

`ifdef COBS_DECODER_ERROR_EN
  localparam logic ERR_BIT = 1'b1;
`else
  localparam logic ERR_BIT = 1'b0;
`endif

  always #5 clk = ~clk;

  cobs_axis_decoder #(
    .S_DATA_WIDTH (8),
    .M_DATA_WIDTH (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .encoded_data_tdata  (enc_tdata),
    .encoded_data_tvalid (enc_tvalid),
    .encoded_data_tready (enc_tready),
    .decoded_data_tdata  (dec_tdata),
    .decoded_data_tkeep  (dec_tkeep),
    .decoded_data_tlast  (dec_tlast),
    .decoded_data_tuser  (dec_tuser),
    .decoded_data_tvalid (dec_tvalid),
    .decoded_data_tready (dec_tready)
  );

  // Record {tdata, tkeep, tlast, tuser} for every handshake at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && dec_tvalid && dec_tready) begin
      cap.push_back({dec_tdata, dec_tkeep, dec_tlast, dec_tuser[0]});
    end
  end

  task automatic send_all();
    for (int i = 0; i < tx.size(); i++) begin
      int n = 0;
      enc_tdata  = tx[i];
      enc_tvalid = 1'b1;
      do begin
        @(negedge clk);
        n++;
      end while (!enc_tready && n < 200);
      total_cnt++;
      if (enc_tready !== 1'b1) begin
        $display("FAIL send_accept byte %0d: tready=%b required 1 within 200 cycles", i, enc_tready);
      end else begin
        pass_cnt++;
      end
      @(posedge clk);
      #1;
      enc_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    enc_tvalid = 1'b1;
    enc_tdata  = 8'h03;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (dec_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b required 0", dec_tvalid);
    else pass_cnt++;
    total_cnt++;
    if ({dec_tdata, dec_tkeep, dec_tlast, dec_tuser} !== 20'h0) begin
      $display("FAIL reset_outputs: got %h required 00000", {dec_tdata, dec_tkeep, dec_tlast, dec_tuser});
    end else pass_cnt++;
    total_cnt++;
    if (enc_tready !== 1'b0) $display("FAIL reset_in_tready: got %b required 0", enc_tready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    enc_tvalid = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_literals();
    cap.delete();
    tx = {8'h03, 8'h71, 8'h69, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 1) $display("FAIL literals_count: got %0d required 1", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'h6971E) $display("FAIL literals_word: got %h required 6971e", cap[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    int n = 0;
    cap.delete();
    tx = {8'h03, 8'h71, 8'h69};
    send_all();
    enc_tdata  = 8'h00;
    enc_tvalid = 1'b1;
    while (!enc_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    enc_tvalid = 1'b0;
    total_cnt++;
    if (dec_tvalid !== 1'b1) $display("FAIL latency_tvalid: got %b required 1 one cycle after delimiter", dec_tvalid);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_implicit_zero();
    cap.delete();
    tx = {8'h02, 8'h71, 8'h02, 8'h69, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 2) $display("FAIL implicit_zero_count: got %0d required 2", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'h0071C) $display("FAIL implicit_zero_word0: got %h required 0071c", cap[0]);
      else pass_cnt++;
      total_cnt++;
      if (cap[1] !== 20'h00696) $display("FAIL implicit_zero_word1: got %h required 00696", cap[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_code_one();
    cap.delete();
    tx = {8'h01, 8'h01, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 1) $display("FAIL code_one_count: got %0d required 1", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'h00006) $display("FAIL code_one_word: got %h required 00006", cap[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_empty();
    cap.delete();
    tx = {8'h00, 8'h00, 8'h01, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 0) $display("FAIL empty_frames: got %0d words required 0", cap.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int not_held = 0;
    int in_open  = 0;
    cap.delete();
    dec_tready = 1'b0;
    tx = {8'h03, 8'h71, 8'h69, 8'h00};
    send_all();
    enc_tvalid = 1'b1;
    enc_tdata  = 8'h02;
    repeat (10) begin
      @(negedge clk);
      if (enc_tready !== 1'b0) in_open++;
      if (dec_tvalid !== 1'b1 || {dec_tdata, dec_tkeep, dec_tlast, dec_tuser} !== 20'h6971E) not_held++;
    end
    total_cnt++;
    if (in_open !== 0) $display("FAIL bp_in_tready: high in %0d of 10 cycles required 0", in_open);
    else pass_cnt++;
    total_cnt++;
    if (not_held !== 0) $display("FAIL bp_hold: word unstable in %0d of 10 cycles required 0", not_held);
    else pass_cnt++;
    @(posedge clk);
    #1;
    enc_tvalid = 1'b0;
    dec_tready = 1'b1;
    drain();
    total_cnt++;
    if (cap.size() !== 1) $display("FAIL bp_count: got %0d required 1", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'h6971E) $display("FAIL bp_word: got %h required 6971e", cap[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_malformed();
    cap.delete();
    tx = {8'h05, 8'h11, 8'h22, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 1) $display("FAIL malformed_count: got %0d required 1", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== {16'h2211, 2'b11, 1'b1, ERR_BIT}) begin
        $display("FAIL malformed_word: got %h required %h", cap[0], {16'h2211, 2'b11, 1'b1, ERR_BIT});
      end else pass_cnt++;
    end
  endtask

  task automatic test_max_code();
    cap.delete();
    tx = {8'hFF};
    for (int i = 1; i <= 254; i++) tx.push_back(8'(i));
    tx.push_back(8'h02);
    tx.push_back(8'h55);
    tx.push_back(8'h00);
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 128) $display("FAIL max_code_count: got %0d required 128", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'h0201C) $display("FAIL max_code_first: got %h required 0201c", cap[0]);
      else pass_cnt++;
      total_cnt++;
      if (cap[126] !== 20'hFEFDC) $display("FAIL max_code_w126: got %h required fefdc", cap[126]);
      else pass_cnt++;
      total_cnt++;
      if (cap[127] !== 20'h00556) $display("FAIL max_code_last: got %h required 00556", cap[127]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    cap.delete();
    tx = {8'h04, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h03, 8'h71, 8'h69, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 3) $display("FAIL b2b_count: got %0d required 3", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'hBBAAC) $display("FAIL b2b_word0: got %h required bbaac", cap[0]);
      else pass_cnt++;
      total_cnt++;
      if (cap[1] !== 20'h00CC6) $display("FAIL b2b_word1: got %h required 00cc6", cap[1]);
      else pass_cnt++;
      total_cnt++;
      if (cap[2] !== 20'h6971E) $display("FAIL b2b_word2: got %h required 6971e", cap[2]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    cap.delete();
    tx = {8'h03, 8'h71};
    send_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tx = {8'h03, 8'h71, 8'h69, 8'h00};
    send_all();
    drain();
    total_cnt++;
    if (cap.size() !== 1) $display("FAIL mid_reset_count: got %0d required 1", cap.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (cap[0] !== 20'h6971E) $display("FAIL mid_reset_word: got %h required 6971e", cap[0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_latency();
    test_implicit_zero();
    test_code_one();
    test_empty();
    test_backpressure();
    test_malformed();
    test_max_code();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
